mr_if: RTL and testbench
========================

// Module: mr_if
// PURPOSE
//  Instruction fetch stage. Issues word fetches to the instruction memory port and buffers
//  responses in an in-order prefetch FIFO, tagging each instruction with its PC.
//  Presents {inst, inst_pc} to decode on a valid/ready handshake.
//  Restarts fetch at a new PC when writeback resolves a taken jump or branch.
// PARAMETERS
//  XLEN         32   address/PC width (matches `XLEN)
//  RESET_PC     0    first fetch address after reset
//  FIFO_DEPTH   4    prefetch FIFO entries (power of 2, >=2)
//  MAX_INFLIGHT 2    max fetches issued but not yet answered
// PORTS
//  clk            in   1     clock
//  rst            in   1     sync reset, active high
//  mem_req_valid  out  1     fetch request valid
//  mem_req_ready  in   1     memory accepts request
//  mem_req_addr   out  XLEN  word-aligned fetch address
//  mem_rsp_valid  in   1     fetch data returned (in request order, no backpressure)
//  mem_rsp_data   in   32    instruction word
//  inst           out  32    instruction to decode (FIFO head)
//  inst_pc        out  XLEN  PC of inst
//  inst_valid     out  1     FIFO non-empty and not flushing
//  inst_ready     in   1     decode consumes head
//  redirect_valid in   1     1-cycle pulse: taken jump/branch resolved
//  redirect_pc    in   XLEN  new fetch PC
//  fetch_fault    out  1     misaligned redirect seen (MR_IF_MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  - Reset: fetch_pc=rsp_pc=RESET_PC; FIFO empty; inflight=0; discard=0; state=FETCH.
//    Outputs after reset: mem_req_valid=0, inst_valid=0, fetch_fault=0, mem_req_addr=RESET_PC.
//  - inflight = requests accepted but not answered, plus 1 while mem_req_valid is held unaccepted.
//  - Issue, state FETCH only: assert mem_req_valid when inflight + fifo_count < FIFO_DEPTH
//    and inflight < MAX_INFLIGHT.
//    - This credit guarantees every response has a FIFO slot.
//    - Once asserted, mem_req_valid and mem_req_addr stay stable until mem_req_ready.
//    - On accept: fetch_pc += 4, modulo 2^XLEN.
//  - Response:
//    - discard>0: data dropped, discard -= 1.
//    - Otherwise push {mem_rsp_data, rsp_pc} and rsp_pc += 4.
//  - Output: inst/inst_pc = FIFO head, combinationally.
//    - Pop on inst_valid & inst_ready.
//    - Push and pop in the same cycle are legal when full or empty; latency rsp->inst_valid = 1 cycle.
//  - Redirect (any state except FAULT):
//    - The pop in that cycle still completes; then the FIFO is flushed.
//    - fetch_pc = rsp_pc = redirect_pc.
//    - discard = inflight after this cycle's events; a response arriving this same cycle is dropped.
//    - A held unaccepted request completes normally and is counted in discard.
//    - Next state = DRAIN if discard>0, else FETCH. inst_valid=0 in the cycle after redirect.
//  - FSM:
//    - FETCH -> DRAIN: redirect with discard>0.
//    - DRAIN: no new issue; -> FETCH when discard==0.
//    - A redirect in DRAIN overwrites the PCs and recomputes discard.
//    - Any -> FAULT: see CONFIGURATION. FAULT -> FETCH only via rst.
//  - rst mid-operation: all state cleared at once; responses to pre-reset requests are not
//    tracked. The memory port must also be reset.
// CONFIGURATION
//  MR_IF_MISALIGN_TRAP_EN defined:
//   - redirect_pc[1:0]!=0 -> state FAULT, fetch_fault=1 (sticky), FIFO flushed, no issue,
//     inst_valid=0.
//  MR_IF_MISALIGN_TRAP_EN undefined:
//   - redirect_pc[1:0] forced to 0; FAULT unreachable; fetch_fault tied 0.
// TESTING
//  1 Reset, mem ready, 1-cycle rsp latency, inst_ready=1
//    -> PCs 0,4,8,C,... issued and delivered in order, one per cycle after fill.
//  2 inst_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) entries held (PCs 0..C), no further
//    mem_req_valid; release -> 0..C then 10.
//  3 mem_req_ready=0 for 5 cycles with mem_req_valid=1
//    -> addr held stable at its value; issue resumes on ready.
//  4 redirect_pc=0x100 while 2 fetches in flight -> DRAIN, 2 responses dropped,
//    next inst_pc=0x100 with its data.
//  5 Redirect coincident with a response and a pop -> popped inst delivered, response dropped,
//    FIFO empty next cycle.
//  6 Misaligned redirect 0x102
//    - MR_IF_MISALIGN_TRAP_EN defined: fetch_fault=1, no requests.
//    - Undefined: fetch from 0x100.

Source files
------------

// File: rtl/mr_if_if.sv
// Fetch-stage signal bundle: instruction memory port, decode handoff and writeback redirect.
// master = fetch stage, slave = memory/decode/writeback side.
interface mr_if_if #(
   parameter int XLEN = 32
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [31:0]     mem_rsp_data;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            fetch_fault;

   modport master (
      output mem_req_valid, mem_req_addr, inst, inst_pc, inst_valid, fetch_fault,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, inst, inst_pc, inst_valid, fetch_fault,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/mr_if.sv
// Instruction fetch: credit-limited word fetches into an in-order PC-tagged prefetch FIFO; rsp->inst_valid 1 cycle,
// decode stalls hold the FIFO and throttle issue. Misaligned-redirect trap enabled by MR_IF_MISALIGN_TRAP_EN.
module mr_if #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              FIFO_DEPTH   = 4,
   parameter int              MAX_INFLIGHT = 2
) (
   input  logic    clk,
   input  logic    rst,
   mr_if_if.master fe
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int IF_W  = $clog2(MAX_INFLIGHT + 2);

   typedef enum logic [1:0] {ST_FETCH, ST_DRAIN, ST_FAULT} state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [XLEN-1:0]  req_addr_q, req_addr_d;
   logic             req_vld_q, req_vld_d;
   logic             fault_q, fault_d;
   logic [IF_W-1:0]  outst_q, outst_d;
   logic [IF_W-1:0]  discard_q, discard_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      data_mem [FIFO_DEPTH];
   logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];

   logic            acc, held, rsp_ok, push, pop, redir, misalign, inst_vld;
   logic [XLEN-1:0] redir_pc;

   assign inst_vld = (count_q != '0) && (state_q != ST_FAULT);
   assign acc      = req_vld_q & fe.mem_req_ready;
   assign held     = req_vld_q & ~fe.mem_req_ready;
   // A response with nothing outstanding can only belong to a request issued before reset.
   assign rsp_ok   = fe.mem_rsp_valid && (outst_q != '0) && (state_q != ST_FAULT);
   assign pop      = inst_vld & fe.inst_ready;
   assign redir    = fe.redirect_valid && (state_q != ST_FAULT);
   assign redir_pc = fe.redirect_pc & ~XLEN'(3);
`ifdef MR_IF_MISALIGN_TRAP_EN
   assign misalign = (fe.redirect_pc[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign push     = rsp_ok && (discard_q == '0) && !redir;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      req_addr_d = req_addr_q;
      req_vld_d  = held;
      fault_d    = fault_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (acc && !rsp_ok) outst_d = outst_q + IF_W'(1);
      else if (!acc && rsp_ok) outst_d = outst_q - IF_W'(1);
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - IF_W'(1);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if ((state_q == ST_DRAIN) && (discard_d == '0)) state_d = ST_FETCH;

      if (redir) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (misalign) begin
            state_d   = ST_FAULT;
            fault_d   = 1'b1;
            req_vld_d = 1'b0;
         end else begin
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            // Everything still owed by memory, including a held request, is now stale.
            discard_d  = outst_d + IF_W'(held);
            state_d    = (discard_d != '0) ? ST_DRAIN : ST_FETCH;
         end
      end else if ((state_q == ST_FETCH) && !held &&
                   (32'(outst_d) + 32'(count_d) < 32'(FIFO_DEPTH)) &&
                   (32'(outst_d) < 32'(MAX_INFLIGHT))) begin
         req_vld_d  = 1'b1;
         req_addr_d = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         req_addr_q <= RESET_PC;
         req_vld_q  <= 1'b0;
         fault_q    <= 1'b0;
         outst_q    <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         req_addr_q <= req_addr_d;
         req_vld_q  <= req_vld_d;
         fault_q    <= fault_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= fe.mem_rsp_data;
         pc_mem[wr_ptr_q]   <= rsp_pc_q;
      end
   end

   assign fe.mem_req_valid = req_vld_q;
   assign fe.mem_req_addr  = req_vld_q ? req_addr_q : fetch_pc_q;
   assign fe.inst          = data_mem[rd_ptr_q];
   assign fe.inst_pc       = pc_mem[rd_ptr_q];
   assign fe.inst_valid    = inst_vld;
   assign fe.fetch_fault   = fault_q;
endmodule

// File: tb/tb_mr_if.sv
// Bench for mr_if: in-order memory model with random latency and a sequential-PC instruction stream
// reference (stream restarts at each redirect target), plus directed fill/stall/redirect scenarios.
module tb_mr_if;
   localparam int XLEN         = 32;
   localparam int FIFO_DEPTH   = 4;
   localparam int MAX_INFLIGHT = 2;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mr_if_if #(.XLEN(XLEN)) bus ();

   mr_if #(
      .XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fe (bus)
   );

   int          checks = 0;
   int          failures = 0;
   rq_t         rspq[$];
   int          cycle, last_due, lat_min, lat_max, rdy_mode, irdy_mode;
   int          delivered = 0;
   int          accepts = 0;
   int          vld_cycles = 0;
   logic [31:0] exp_pc, prev_addr, last_pop_pc, redir_tgt;
   bit          prev_held, expect_iv0, redir_go, had_rsp, had_pop;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic set_env(input int r, input int ir, input int lmin, input int lmax);
      rdy_mode  = r;
      irdy_mode = ir;
      lat_min   = lmin;
      lat_max   = lmax;
   endtask

   // One clock: drive inputs at negedge, score what the next posedge will do, advance.
   task automatic cyc();
      bit rsp, acc, pop;
      int due;
      bus.mem_req_ready = (rdy_mode == 0) || ((rdy_mode == 2) && ($urandom_range(0, 3) != 0));
      bus.inst_ready    = (irdy_mode == 0) || ((irdy_mode == 2) && ($urandom_range(0, 2) != 0));
      rsp = (rspq.size() > 0) && (rspq[0].due <= cycle);
      bus.mem_rsp_valid  = rsp;
      bus.mem_rsp_data   = rsp ? memfn(rspq[0].addr) : $urandom;
      bus.redirect_valid = redir_go;
      bus.redirect_pc    = redir_tgt;
      #1;
      if (expect_iv0) chk("inst_valid_after_redirect", 32'(bus.inst_valid), 32'd0);
      expect_iv0 = 1'b0;
      if (prev_held) begin
         chk("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
         chk("req_hold_addr", bus.mem_req_addr, prev_addr);
      end
      chk("inflight_bound", 32'((rspq.size() + int'(bus.mem_req_valid)) <= MAX_INFLIGHT), 32'd1);
      acc = bus.mem_req_valid && bus.mem_req_ready;
      pop = bus.inst_valid && bus.inst_ready;
      if (pop) begin
         chk("inst_pc", bus.inst_pc, exp_pc);
         chk("inst_data", bus.inst, memfn(exp_pc));
         last_pop_pc = bus.inst_pc;
         exp_pc      = exp_pc + 32'd4;
         delivered++;
      end
      if (rsp) void'(rspq.pop_front());
      if (acc) begin
         due = cycle + int'($urandom_range(lat_min, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rspq.push_back('{addr: bus.mem_req_addr, due: due});
         accepts++;
      end
      if (bus.mem_req_valid) vld_cycles++;
      prev_held = bus.mem_req_valid && !bus.mem_req_ready;
      prev_addr = bus.mem_req_addr;
      if (redir_go) begin
`ifdef MR_IF_MISALIGN_TRAP_EN
         if (redir_tgt[1:0] != 2'b00) prev_held = 1'b0;
`endif
         exp_pc     = redir_tgt & 32'hFFFF_FFFC;
         expect_iv0 = 1'b1;
         had_rsp    = rsp;
         had_pop    = pop;
         redir_go   = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cycle++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = '0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      rspq.delete();
      cycle       = 0;
      last_due    = -1;
      exp_pc      = 32'h0;
      prev_held   = 1'b0;
      expect_iv0  = 1'b0;
      redir_go    = 1'b0;
      last_pop_pc = 32'hFFFF_FFFF;
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
      chk("rst_req_addr", bus.mem_req_addr, 32'h0);
   endtask

   initial begin
      int d0, a0, v0, n;
      redir_tgt = '0;
      set_env(0, 0, 1, 1);

      // Streaming: one instruction per cycle once the pipe is full.
      do_reset();
      set_env(0, 0, 1, 1);
      repeat (5) cyc();
      d0 = delivered;
      repeat (10) cyc();
      chk("t1_one_per_cycle", delivered - d0, 10);

      // Decode stall: FIFO fills to depth and issue stops.
      do_reset();
      set_env(0, 1, 1, 1);
      a0 = accepts;
      repeat (10) cyc();
      v0 = vld_cycles;
      repeat (10) cyc();
      chk("t2_accepts", accepts - a0, FIFO_DEPTH);
      chk("t2_no_issue_when_full", vld_cycles - v0, 0);
      chk("t2_head_valid", 32'(bus.inst_valid), 32'd1);
      chk("t2_head_pc", bus.inst_pc, 32'h0);
      irdy_mode = 0;
      d0 = delivered;
      repeat (8) cyc();
      chk("t2_release", 32'((delivered - d0) >= 5), 32'd1);

      // Memory backpressure: held request stays stable.
      do_reset();
      set_env(1, 0, 1, 1);
      repeat (6) cyc();
      chk("t3_valid_held", 32'(bus.mem_req_valid), 32'd1);
      chk("t3_addr_held", bus.mem_req_addr, 32'h0);
      a0 = accepts;
      rdy_mode = 0;
      repeat (10) cyc();
      chk("t3_resume", 32'((accepts - a0) >= 4), 32'd1);

      // Redirect with two fetches in flight.
      do_reset();
      set_env(0, 0, 3, 3);
      n = 0;
      while ((rspq.size() < 2) && (n < 20)) begin
         cyc();
         n++;
      end
      chk("t4_two_inflight", rspq.size(), 2);
      redir_tgt = 32'h100;
      redir_go  = 1'b1;
      cyc();
      d0 = delivered;
      n  = 0;
      while ((delivered == d0) && (n < 40)) begin
         cyc();
         n++;
      end
      chk("t4_first_pc", last_pop_pc, 32'h100);

      // Redirect coincident with response and pop; target wraps past the top of memory.
      do_reset();
      set_env(0, 0, 1, 1);
      repeat (6) cyc();
      redir_tgt = 32'hFFFF_FFF8;
      redir_go  = 1'b1;
      cyc();
      chk("t5_rsp_same_cycle", 32'(had_rsp), 32'd1);
      chk("t5_pop_same_cycle", 32'(had_pop), 32'd1);
      chk("t5_fifo_empty", 32'(bus.inst_valid), 32'd0);
      d0 = delivered;
      n  = 0;
      while (((delivered - d0) < 4) && (n < 40)) begin
         cyc();
         n++;
      end
      chk("t5_wrap_pc", last_pop_pc, 32'h4);

      // Misaligned redirect.
      redir_tgt = 32'h102;
      redir_go  = 1'b1;
      cyc();
`ifdef MR_IF_MISALIGN_TRAP_EN
      v0 = vld_cycles;
      repeat (10) cyc();
      chk("t6_fault", 32'(bus.fetch_fault), 32'd1);
      chk("t6_no_requests", vld_cycles - v0, 0);
      chk("t6_no_inst", 32'(bus.inst_valid), 32'd0);
`else
      d0 = delivered;
      n  = 0;
      while ((delivered == d0) && (n < 40)) begin
         cyc();
         n++;
      end
      chk("t6_first_pc", last_pop_pc, 32'h100);
      chk("t6_no_fault", 32'(bus.fetch_fault), 32'd0);
`endif

      // Randomized traffic, redirects and one mid-run reset.
      do_reset();
      set_env(2, 2, 1, 3);
      d0 = delivered;
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) begin
            do_reset();
         end else if ($urandom_range(0, 29) == 0) begin
            redir_go = 1'b1;
`ifdef MR_IF_MISALIGN_TRAP_EN
            redir_tgt = $urandom & 32'h0000_0FFC;
`else
            redir_tgt = $urandom & 32'h0000_0FFF;
`endif
         end
         cyc();
      end
      chk("rand_progress", 32'((delivered - d0) > 200), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
